// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants, fetch-unit state encoding and next-PC select codes.
// Imported by the fetch unit and its next-PC sub-module.
package cpu_isa_pkg;

    localparam logic [5:0] OP_NOOP = 6'b000000;
    localparam logic [5:0] OP_JUMP = 6'b000001;
    localparam logic [5:0] OP_BEQ  = 6'b100000;
    localparam logic [5:0] OP_BNE  = 6'b100001;
    localparam logic [5:0] OP_BLT  = 6'b100010;
    localparam logic [5:0] OP_BLE  = 6'b100011;

    // An all-zero word decodes as NOOP, so a freshly reset IR is harmless.
    localparam logic [31:0] INSTR_RESET = {OP_NOOP, 26'd0};

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BR_WAIT = 2'd2
    } ifu_state_e;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2
    } npc_sel_e;

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BLE);
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-PC selection: sequential, PC-relative branch, absolute jump.
// All arithmetic is 32-bit modulo, so negative offsets and 0xFFFFFFFF+1 wrap.
module ifu_next_pc
    import cpu_isa_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm_sext,
    input  logic [25:0] jump_target,
    input  npc_sel_e    sel,
    output logic [31:0] next_pc
);

    logic [31:0] pc_inc;

    assign pc_inc = pc + 32'd1;

    always_comb begin
        next_pc = pc_inc;
        case (sel)
            NPC_BRANCH: next_pc = pc_inc + imm_sext;
            NPC_JUMP:   next_pc = {6'b0, jump_target};
            default:    next_pc = pc_inc;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: FETCH latches the word at PC, ISSUE offers it to the
// control unit, BR_WAIT parks the PC until the branch compare resolves.
module instr_fetch_unit
    import cpu_isa_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [5:0]  JUMP_OP  = OP_JUMP
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic [5:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [31:0] imm_sext,
    input  logic        br_resolve,
    input  logic        br_taken,
    input  logic        stall
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic [31:0] next_pc;
    npc_sel_e    npc_sel;
    logic        pc_load;

    assign imem_pc  = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign opcode   = ir_q[31:26];
    assign rd       = ir_q[25:21];
    assign rs       = ir_q[20:16];
    assign rt       = ir_q[15:11];
    assign imm_sext = sext16(ir_q[15:0]);
    assign ir_valid = (state_q == ST_ISSUE);

    ifu_next_pc u_next_pc (
        .pc          (pc_q),
        .imm_sext    (imm_sext),
        .jump_target (ir_q[25:0]),
        .sel         (npc_sel),
        .next_pc     (next_pc)
    );

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        state_d = state_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        npc_sel = NPC_SEQ;
        pc_load = 1'b0;
        if (!stall) begin
            case (state_q)
                ST_FETCH: begin
                    ir_d    = imem_instr;
                    ir_pc_d = pc_q;
                    state_d = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (ir_ready) begin
                        // Branches keep the PC on the branch itself; BR_WAIT adds the offset.
                        if (is_branch(opcode)) begin
                            state_d = ST_BR_WAIT;
                        end else begin
                            npc_sel = (opcode == JUMP_OP) ? NPC_JUMP : NPC_SEQ;
                            pc_load = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_BR_WAIT: begin
                    if (br_resolve) begin
                        npc_sel = br_taken ? NPC_BRANCH : NPC_SEQ;
                        pc_load = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_d = pc_load ? next_pc : pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= INSTR_RESET;
            ir_pc_q <= 32'd0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a scoreboard of expected (ir_pc, ir)
// pairs is popped at every handshake; scenario tasks check PC and flow inline.
module tb_instr_fetch_unit;

    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_SUBI = 6'b001010;
    localparam logic [5:0] T_JUMP = 6'b000001;
    localparam logic [5:0] T_BEQ  = 6'b100000;
    localparam logic [5:0] T_BNE  = 6'b100001;
    localparam logic [5:0] T_BLE  = 6'b100011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm_sext;
    logic        br_resolve;
    logic        br_taken;
    logic        stall;

    logic [31:0] mem [64];
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int          pop_count = 0;

    assign imem_instr = mem[imem_pc[5:0]];

    instr_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_pc    (imem_pc),
        .imem_instr (imem_instr),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .opcode     (opcode),
        .rd         (rd),
        .rs         (rs),
        .rt         (rt),
        .imm_sext   (imm_sext),
        .br_resolve (br_resolve),
        .br_taken   (br_taken),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: a handshake happens at the next rising edge when these hold.
    always @(negedge clk) begin
        if (rst_n && ir_valid && ir_ready && !stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got ir_pc=%h ir=%h, required no issue", ir_pc, ir);
            end else begin
                mon_e = exp_q.pop_front();
                if (ir_pc !== mon_e.pc || ir !== mon_e.instr) begin
                    errors++;
                    $display("FAIL issue: got ir_pc=%h ir=%h, required ir_pc=%h ir=%h",
                             ir_pc, ir, mon_e.pc, mon_e.instr);
                end
            end
            pop_count++;
        end
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] r_d,
                                          input logic [4:0] r_s, input logic [15:0] imm);
        return {op, r_d, r_s, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {T_JUMP, target};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back('{pc: pc, instr: mem[pc[5:0]]});
    endtask

    // Returns right after the edge on which the n-th further handshake is taken.
    task automatic wait_issues(input int n, input string name);
        int target;
        int budget;
        target = pop_count + n;
        budget = 40;
        while (pop_count < target && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        checks++;
        if (pop_count < target) begin
            errors++;
            $display("FAIL %s_timeout: got %0d issues, required %0d", name, pop_count, target);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        ir_ready   = 1'b0;
        stall      = 1'b0;
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d pending, required 0", exp_q.size());
        end
        exp_q.delete();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ir_ready = 1'b0; stall = 1'b0; br_resolve = 1'b0; br_taken = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        #3;
        checks++;
        if (imem_pc !== 32'd0 || ir_valid !== 1'b0 || ir !== 32'd0 || ir_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got pc=%h valid=%b ir=%h ir_pc=%h, required 0/0/0/0",
                     imem_pc, ir_valid, ir, ir_pc);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        mem[0] = enc_i(T_ADDI, 5'd3, 5'd4, 16'h8005);
        mem[1] = enc_i(T_SUBI, 5'd5, 5'd6, 16'h0001);
        mem[2] = enc_i(T_ADDI, 5'd7, 5'd8, 16'h7fff);
        mem[3] = enc_i(T_SUBI, 5'd9, 5'd1, 16'h0010);
        mem[4] = enc_i(T_ADDI, 5'd2, 5'd2, 16'hffff);
        for (int p = 0; p < 5; p++) push_exp(p);
        ir_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ir_valid !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL seq_valid_cycle%0d: got %b, required %b", i, ir_valid, (i % 2) == 0);
            end
            if (i == 0) begin
                checks++;
                if (opcode !== T_ADDI || rd !== 5'd3 || rs !== 5'd4 || rt !== 5'b10000 ||
                    imm_sext !== 32'hffff8005) begin
                    errors++;
                    $display("FAIL decode_neg: got op=%h rd=%0d rs=%0d rt=%0d imm=%h, required 08/3/4/16/ffff8005",
                             opcode, rd, rs, rt, imm_sext);
                end
            end
            if (i == 4) begin
                checks++;
                if (imm_sext !== 32'h00007fff || rt !== 5'b01111) begin
                    errors++;
                    $display("FAIL decode_pos: got imm=%h rt=%0d, required 00007fff/15", imm_sext, rt);
                end
            end
        end
        ir_ready = 1'b0;
        checks++;
        if (imem_pc !== 32'd5) begin
            errors++;
            $display("FAIL seq_end_pc: got %h, required 5", imem_pc);
        end
    endtask

    task automatic test_branch();
        do_reset();
        mem[0]  = enc_j(26'd14);
        mem[14] = enc_i(T_BEQ, 5'd1, 5'd2, 16'hfff1);
        push_exp(0);
        push_exp(14);
        ir_ready = 1'b1;
        wait_issues(2, "beq_first");
        checks++;
        if (imem_pc !== 32'd14 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL beq_wait: got pc=%h valid=%b, required 14/0", imem_pc, ir_valid);
        end
        br_taken = 1'b1;
        tick();
        tick();
        checks++;
        if (imem_pc !== 32'd14 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL taken_without_resolve: got pc=%h valid=%b, required 14/0", imem_pc, ir_valid);
        end
        push_exp(0);
        push_exp(14);
        br_resolve = 1'b1;
        tick();
        br_resolve = 1'b0;
        checks++;
        if (imem_pc !== 32'd0) begin
            errors++;
            $display("FAIL beq_taken_pc: got %h, required 0", imem_pc);
        end
        wait_issues(2, "beq_second");
        push_exp(15);
        br_taken   = 1'b0;
        br_resolve = 1'b1;
        tick();
        br_resolve = 1'b0;
        checks++;
        if (imem_pc !== 32'd15) begin
            errors++;
            $display("FAIL beq_not_taken_pc: got %h, required f", imem_pc);
        end
        wait_issues(1, "noop_15");
        ir_ready = 1'b0;
        checks++;
        if (imem_pc !== 32'd16) begin
            errors++;
            $display("FAIL noop_next_pc: got %h, required 10", imem_pc);
        end
    endtask

    task automatic test_ble_jump();
        do_reset();
        mem[0]  = enc_j(26'd29);
        mem[28] = enc_i(T_ADDI, 5'd4, 5'd4, 16'h0002);
        mem[29] = enc_i(T_BLE, 5'd6, 5'd7, 16'hfffe);
        mem[30] = enc_j(26'd0);
        push_exp(0);
        push_exp(29);
        ir_ready = 1'b1;
        wait_issues(2, "ble_first");
        push_exp(28);
        push_exp(29);
        br_taken   = 1'b1;
        br_resolve = 1'b1;
        tick();
        br_resolve = 1'b0;
        checks++;
        if (imem_pc !== 32'd28) begin
            errors++;
            $display("FAIL ble_taken_pc: got %h, required 1c", imem_pc);
        end
        wait_issues(2, "ble_second");
        push_exp(30);
        br_taken   = 1'b0;
        br_resolve = 1'b1;
        tick();
        br_resolve = 1'b0;
        checks++;
        if (imem_pc !== 32'd30) begin
            errors++;
            $display("FAIL ble_not_taken_pc: got %h, required 1e", imem_pc);
        end
        wait_issues(1, "jump_30");
        ir_ready = 1'b0;
        checks++;
        if (imem_pc !== 32'd0 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_target: got pc=%h valid=%b, required 0/0", imem_pc, ir_valid);
        end
        tick();
        checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 32'd0 || ir !== mem[0]) begin
            errors++;
            $display("FAIL jump_no_brwait: got valid=%b ir_pc=%h ir=%h, required 1/0/%h",
                     ir_valid, ir_pc, ir, mem[0]);
        end
    endtask

    task automatic test_backpressure_stall();
        do_reset();
        mem[0] = enc_i(T_ADDI, 5'd1, 5'd1, 16'h0003);
        mem[1] = enc_i(T_BNE, 5'd2, 5'd3, 16'h0005);
        br_resolve = 1'b1;
        br_taken   = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ir_valid !== 1'b1 || ir !== mem[0] || ir_pc !== 32'd0 || imem_pc !== 32'd0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b ir=%h ir_pc=%h pc=%h, required 1/%h/0/0",
                         i, ir_valid, ir, ir_pc, imem_pc, mem[0]);
            end
        end
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        stall      = 1'b1;
        ir_ready   = 1'b1;
        tick();
        tick();
        checks++;
        if (ir_valid !== 1'b1 || imem_pc !== 32'd0) begin
            errors++;
            $display("FAIL stall_over_ready: got valid=%b pc=%h, required 1/0", ir_valid, imem_pc);
        end
        push_exp(0);
        push_exp(1);
        stall = 1'b0;
        wait_issues(2, "bne");
        stall      = 1'b1;
        br_resolve = 1'b1;
        br_taken   = 1'b1;
        tick();
        stall      = 1'b0;
        br_resolve = 1'b0;
        tick();
        checks++;
        if (imem_pc !== 32'd1 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_over_resolve: got pc=%h valid=%b, required 1/0", imem_pc, ir_valid);
        end
        br_resolve = 1'b1;
        tick();
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        checks++;
        if (imem_pc !== 32'd7) begin
            errors++;
            $display("FAIL bne_taken_pc: got %h, required 7", imem_pc);
        end
        stall = 1'b1;
        tick();
        tick();
        checks++;
        if (ir_valid !== 1'b0 || imem_pc !== 32'd7) begin
            errors++;
            $display("FAIL stall_in_fetch: got valid=%b pc=%h, required 0/7", ir_valid, imem_pc);
        end
        stall = 1'b0;
        tick();
        ir_ready = 1'b0;
        checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 32'd7) begin
            errors++;
            $display("FAIL fetch_after_stall: got valid=%b ir_pc=%h, required 1/7", ir_valid, ir_pc);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        mem[0]  = enc_j(26'd19);
        mem[19] = enc_i(T_BEQ, 5'd1, 5'd1, 16'h0003);
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ir_valid !== 1'b0 || imem_pc !== 32'd0 || ir !== 32'd0 || ir_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_issue: got valid=%b pc=%h ir=%h ir_pc=%h, required 0/0/0/0",
                     ir_valid, imem_pc, ir, ir_pc);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_exp(0);
        push_exp(19);
        ir_ready = 1'b1;
        wait_issues(2, "beq_19");
        ir_ready = 1'b0;
        checks++;
        if (imem_pc !== 32'd19) begin
            errors++;
            $display("FAIL brwait_19: got pc=%h, required 13", imem_pc);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ir_valid !== 1'b0 || imem_pc !== 32'd0 || ir !== 32'd0 || ir_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_brwait: got valid=%b pc=%h ir=%h ir_pc=%h, required 0/0/0/0",
                     ir_valid, imem_pc, ir, ir_pc);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        br_resolve = 1'b1;
        br_taken   = 1'b1;
        tick();
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 32'd0 || ir !== mem[0]) begin
            errors++;
            $display("FAIL fetch_after_reset: got valid=%b ir_pc=%h ir=%h, required 1/0/%h",
                     ir_valid, ir_pc, ir, mem[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        mem[0]  = enc_j(26'd14);
        mem[14] = enc_i(T_BEQ, 5'd2, 5'd2, 16'hfff0);
        mem[63] = enc_i(T_SUBI, 5'd8, 5'd9, 16'h0004);
        push_exp(0);
        push_exp(14);
        ir_ready = 1'b1;
        wait_issues(2, "beq_wrap");
        push_exp(32'hffffffff);
        br_taken   = 1'b1;
        br_resolve = 1'b1;
        tick();
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        checks++;
        if (imem_pc !== 32'hffffffff) begin
            errors++;
            $display("FAIL negative_wrap_pc: got %h, required ffffffff", imem_pc);
        end
        wait_issues(1, "wrap_issue");
        ir_ready = 1'b0;
        checks++;
        if (imem_pc !== 32'd0) begin
            errors++;
            $display("FAIL pc_wrap_to_zero: got %h, required 0", imem_pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_ble_jump();
        test_backpressure_stall();
        test_reset_midflight();
        test_wrap();
        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0: word address loaded into the PC at reset.
REQ-002 SHALL have parameter JUMP_OP, default 6'b000001: opcode of the absolute jump.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port imem_pc, output, 32 bits: word address presented to instruction memory.
REQ-006 SHALL have port imem_instr, input, 32 bits: instruction word returned combinationally for imem_pc.
REQ-007 SHALL have port ir_valid, output, 1 bit: latched instruction available to control unit.
REQ-008 SHALL have port ir_ready, input, 1 bit: control unit accepts the latched instruction.
REQ-009 SHALL have port ir, output, 32 bits: latched instruction register.
REQ-010 SHALL have port ir_pc, output, 32 bits: PC of the instruction in ir.
REQ-011 SHALL have port opcode, output, 6 bits: ir[31:26].
REQ-012 SHALL have ports rd, rs, rt, outputs, 5 bits each: ir[25:21], ir[20:16], ir[15:11].
REQ-013 SHALL have port imm_sext, output, 32 bits: ir[15:0] sign-extended.
REQ-014 SHALL have port br_resolve, input, 1 bit: single-cycle strobe, branch compare complete.
REQ-015 SHALL have port br_taken, input, 1 bit: branch outcome; qualified by br_resolve.
REQ-016 SHALL have port stall, input, 1 bit: freezes the FSM and PC while high.

Function
REQ-017 SHALL implement states FETCH, ISSUE, BR_WAIT.
REQ-018 imem_pc SHALL equal the PC register at all times.
REQ-019 FETCH (stall low): ir <= imem_instr, ir_pc <= PC, go to ISSUE next cycle.
REQ-020 ISSUE: ir_valid=1; ir, ir_pc stable until handshake (ir_valid & ir_ready).
REQ-021 Handshake, opcode 100000..100011 (BEQ/BNE/BLT/BLE): go to BR_WAIT, PC unchanged.
REQ-022 Handshake, opcode == JUMP_OP: PC <= {6'b0, ir[25:0]}, go to FETCH.
REQ-023 Handshake, any other opcode (NOOP included): PC <= PC + 1, go to FETCH.
REQ-024 BR_WAIT: ir_valid=0; on br_resolve, PC <= br_taken ? PC+1+imm_sext : PC+1, go to FETCH.
REQ-025 br_resolve outside BR_WAIT SHALL be ignored; br_taken without br_resolve SHALL be ignored.
REQ-026 PC arithmetic SHALL be 32-bit modulo: 32'hFFFFFFFF + 1 = 0; negative offsets wrap.
REQ-027 stall high SHALL hold state, PC, ir; it overrides ir_ready and br_resolve in the same cycle.
REQ-028 ir_valid SHALL be a registered state decode, with no combinational path from ir_ready.
REQ-029 Minimum throughput: one non-branch instruction per 2 cycles with ir_ready held high.

Reset
REQ-030 rst_n low SHALL asynchronously set PC=RESET_PC, state=FETCH, ir=0, ir_pc=0, ir_valid=0.
REQ-031 Reset mid-ISSUE or mid-BR_WAIT SHALL discard the pending instruction/branch; the first fetch after release is from RESET_PC.

Structure
REQ-032 Opcode constants (NOOP, JUMP, BEQ, BNE, BLT, BLE) and state encoding SHALL live in shared package cpu_isa_pkg.
REQ-033 Next-PC selection (PC+1, branch target, jump target) SHALL be one combinational sub-module, ifu_next_pc.

Verification
REQ-034 Reset, imem returns addi/subi at PC 0..4, ir_ready=1 -> ir_pc sequence 0,1,2,3,4, one ir_valid pulse every 2 cycles.
REQ-035 BEQ at PC 14 with imm 0xFFF1, br_resolve and br_taken=1 -> next fetch PC 0; with br_taken=0 -> PC 15.
REQ-036 BLE at PC 29 with imm 0xFFFE, taken -> PC 28; jump at PC 30 with ir[25:0]=0 -> PC 0, no BR_WAIT.
REQ-037 ir_ready low 5 cycles in ISSUE -> ir_valid stays 1, ir/ir_pc constant, PC constant; stall pulse during BR_WAIT with br_resolve -> resolve ignored.
REQ-038 rst_n asserted in BR_WAIT at PC 19 -> ir_valid=0 immediately; after release imem_pc=RESET_PC.
REQ-039 PC=32'hFFFFFFFF, non-branch handshake -> PC wraps to 0.
